// File: rtl/idu_pkg.sv
// Shared decode definitions for the RV32I issue stage: ALU op codes, opcodes,
// immediate kinds and the packet handed to the EXU.
package idu_pkg;

    localparam int unsigned XLEN_W = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_COPYB = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_type_e;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] alu_a;
        logic [XLEN_W-1:0] alu_b;
        logic [3:0]        alu_ctr;
        logic [4:0]        rd;
        logic              rd_wen;
        logic              is_branch;
        logic              is_jump;
        logic [2:0]        br_type;
        logic [XLEN_W-1:0] target;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        mem_funct3;
        logic [XLEN_W-1:0] store_data;
        logic              ebreak;
        logic              illegal;
    } idu_pkt_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e kind);
        logic [31:0] imm;
        case (kind)
            IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     imm = {inst[31:12], 12'h000};
            IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_SHAMT: imm = {27'h0, inst[24:20]};
            default:   imm = 32'h0;
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA over ADD/SRL (funct7[5]).
    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Combinational RV32I decoder: instruction, PC and register data to an issue packet.
module idu_decode_comb
    import idu_pkg::*;
(
    input  logic [XLEN_W-1:0] inst,
    input  logic [XLEN_W-1:0] pc,
    input  logic [XLEN_W-1:0] rs1_data,
    input  logic [XLEN_W-1:0] rs2_data,
    output idu_pkt_t          pkt
);

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic              legal;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = imm_gen(inst, IMM_I);
    assign imm_s  = imm_gen(inst, IMM_S);
    assign imm_b  = imm_gen(inst, IMM_B);
    assign imm_u  = imm_gen(inst, IMM_U);
    assign imm_j  = imm_gen(inst, IMM_J);
    assign imm_sh = imm_gen(inst, IMM_SHAMT);

    always_comb begin
        pkt            = '0;
        legal          = 1'b0;
        pkt.pc         = pc;
        pkt.rd         = rd;
        pkt.store_data = rs2_data;
        case (opcode)
            OP_LUI: begin
                legal       = 1'b1;
                pkt.alu_ctr = ALU_COPYB;
                pkt.alu_b   = imm_u;
                pkt.rd_wen  = 1'b1;
            end
            OP_AUIPC: begin
                legal       = 1'b1;
                pkt.alu_ctr = ALU_ADD;
                pkt.alu_a   = pc;
                pkt.alu_b   = imm_u;
                pkt.rd_wen  = 1'b1;
            end
            OP_JAL: begin
                legal       = 1'b1;
                pkt.alu_a   = pc;
                pkt.alu_b   = 32'd4;
                pkt.is_jump = 1'b1;
                pkt.rd_wen  = 1'b1;
                pkt.target  = pc + imm_j;
            end
            OP_JALR: begin
                legal       = (funct3 == 3'b000);
                pkt.alu_a   = pc;
                pkt.alu_b   = 32'd4;
                pkt.is_jump = 1'b1;
                pkt.rd_wen  = 1'b1;
                pkt.target  = (rs1_data + imm_i) & ~32'h1;
            end
            OP_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                legal         = (funct3[2:1] != 2'b01);
                pkt.alu_a     = rs1_data;
                pkt.alu_b     = rs2_data;
                pkt.is_branch = 1'b1;
                pkt.br_type   = funct3;
                pkt.target    = pc + imm_b;
                case (funct3[2:1])
                    2'b00:   pkt.alu_ctr = ALU_SUB;
                    2'b10:   pkt.alu_ctr = ALU_SLT;
                    default: pkt.alu_ctr = ALU_SLTU;
                endcase
            end
            OP_LOAD: begin
                legal          = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                pkt.alu_a      = rs1_data;
                pkt.alu_b      = imm_i;
                pkt.mem_rd     = 1'b1;
                pkt.mem_funct3 = funct3;
                pkt.rd_wen     = 1'b1;
            end
            OP_STORE: begin
                legal          = (funct3 inside {3'b000, 3'b001, 3'b010});
                pkt.alu_a      = rs1_data;
                pkt.alu_b      = imm_s;
                pkt.mem_wr     = 1'b1;
                pkt.mem_funct3 = funct3;
            end
            OP_IMM: begin
                legal       = 1'b1;
                pkt.alu_a   = rs1_data;
                pkt.alu_b   = imm_i;
                pkt.alu_ctr = alu_op(funct3, 1'b0);
                pkt.rd_wen  = 1'b1;
                // only the shift forms constrain funct7; elsewhere it is immediate
                if (funct3 == 3'b001) begin
                    legal     = (funct7 == 7'b0000000);
                    pkt.alu_b = imm_sh;
                end else if (funct3 == 3'b101) begin
                    legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    pkt.alu_b   = imm_sh;
                    pkt.alu_ctr = alu_op(funct3, funct7[5]);
                end
            end
            OP_OP: begin
                legal       = (funct7 == 7'b0000000) ||
                              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                pkt.alu_a   = rs1_data;
                pkt.alu_b   = rs2_data;
                pkt.alu_ctr = alu_op(funct3, funct7[5]);
                pkt.rd_wen  = 1'b1;
            end
            OP_SYSTEM: begin
                legal      = (inst == INST_EBREAK);
                pkt.ebreak = 1'b1;
            end
            default: ;
        endcase

        if (!legal) begin
            pkt            = '0;
            pkt.pc         = pc;
            pkt.rd         = rd;
            pkt.store_data = rs2_data;
            pkt.illegal    = 1'b1;
        end
        if (rd == 5'd0) begin
            pkt.rd_wen = 1'b0;
        end
    end

endmodule

// File: rtl/idu_alu_issue.sv
// RV32I decode/issue stage: valid/ready in from IFU, registered packet out to EXU.
// Optional one-entry skid buffer enabled by defining IDU_SKID_EN.
module idu_alu_issue
    import idu_pkg::*;
#(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_alu_a,
    output logic [XLEN-1:0] out_alu_b,
    output logic [3:0]      out_alu_ctr,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic [2:0]      out_br_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [2:0]      out_mem_funct3,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_ebreak,
    output logic            out_illegal
);

    idu_pkt_t dec_pkt;
    idu_pkt_t out_pkt_q, out_pkt_d;
    logic     out_valid_q, out_valid_d;
    logic     in_fire, out_fire;

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    idu_decode_comb u_decode (
        .inst     (in_inst),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pkt      (dec_pkt)
    );

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

`ifdef IDU_SKID_EN
    idu_pkt_t skid_pkt_q, skid_pkt_d;
    logic     skid_valid_q, skid_valid_d;

    // Ready depends only on skid occupancy, breaking the out_ready path.
    assign in_ready = ~skid_valid_q & ~flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pkt_d    = out_pkt_q;
        skid_valid_d = skid_valid_q;
        skid_pkt_d   = skid_pkt_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_pkt_d    = skid_pkt_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_pkt_d   = dec_pkt;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_pkt_d   = dec_pkt;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_pkt_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pkt_q   <= skid_pkt_d;
        end
    end
`else
    assign in_ready = ~flush & (~out_valid_q | out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_pkt_d   = out_pkt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_pkt_d   = dec_pkt;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
            out_pkt_q.pc <= RESET_PC_TAG;
        end else begin
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pkt_q.pc;
    assign out_alu_a      = out_pkt_q.alu_a;
    assign out_alu_b      = out_pkt_q.alu_b;
    assign out_alu_ctr    = out_pkt_q.alu_ctr;
    assign out_rd         = out_pkt_q.rd;
    assign out_rd_wen     = out_pkt_q.rd_wen;
    assign out_is_branch  = out_pkt_q.is_branch;
    assign out_is_jump    = out_pkt_q.is_jump;
    assign out_br_type    = out_pkt_q.br_type;
    assign out_target     = out_pkt_q.target;
    assign out_mem_rd     = out_pkt_q.mem_rd;
    assign out_mem_wr     = out_pkt_q.mem_wr;
    assign out_mem_funct3 = out_pkt_q.mem_funct3;
    assign out_store_data = out_pkt_q.store_data;
    assign out_ebreak     = out_pkt_q.ebreak;
    assign out_illegal    = out_pkt_q.illegal;

endmodule

// File: tb/tb_idu_alu_issue.sv
// Bench for idu_alu_issue: vector table driven through a scoreboard, plus
// stall, flush and mid-stall reset sequences.
module tb_idu_alu_issue;
    import idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_alu_a, out_alu_b, out_target, out_store_data;
    logic [3:0]  out_alu_ctr;
    logic [4:0]  out_rd;
    logic        out_rd_wen, out_is_branch, out_is_jump, out_mem_rd, out_mem_wr;
    logic        out_ebreak, out_illegal;
    logic [2:0]  out_br_type, out_mem_funct3;

    always #5 clk = ~clk;

    idu_alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_ctr(out_alu_ctr),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_branch(out_is_branch),
        .out_is_jump(out_is_jump), .out_br_type(out_br_type), .out_target(out_target),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_mem_funct3(out_mem_funct3),
        .out_store_data(out_store_data), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
    );

    localparam logic [6:0] F_WEN = 7'b1000000;
    localparam logic [6:0] F_BR  = 7'b0100000;
    localparam logic [6:0] F_J   = 7'b0010000;
    localparam logic [6:0] F_MRD = 7'b0001000;
    localparam logic [6:0] F_MWR = 7'b0000100;
    localparam logic [6:0] F_EB  = 7'b0000010;
    localparam logic [6:0] F_ILL = 7'b0000001;
    localparam logic [6:0] F_NO  = 7'b0000000;

    typedef struct {
        logic [31:0] inst, pc, rs1, rs2;
        logic [3:0]  ctr;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [6:0]  fl;
        logic [2:0]  brt;
        logic [31:0] tgt;
        logic [2:0]  mf3;
    } vec_t;

    vec_t     vecs[$];
    idu_pkt_t sb[$];
    idu_pkt_t cur_exp = '0;
    idu_pkt_t act, held;
    logic     prev_hold = 1'b0;
    logic     ready_rand = 1'b0;
    int       n_cmp = 0;
    int       n_err = 0;

    function automatic vec_t mk(input logic [31:0] inst, pc, rs1, rs2, input logic [3:0] ctr,
                                input logic [31:0] a, b, input logic [4:0] rd, input logic [6:0] fl,
                                input logic [2:0] brt, input logic [31:0] tgt, input logic [2:0] mf3);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.ctr = ctr; v.a = a; v.b = b;
        v.rd = rd; v.fl = fl; v.brt = brt; v.tgt = tgt; v.mf3 = mf3;
        return v;
    endfunction

    function automatic idu_pkt_t exp_of(input vec_t v);
        idu_pkt_t p;
        p = '0;
        p.pc = v.pc; p.alu_a = v.a; p.alu_b = v.b; p.alu_ctr = v.ctr; p.rd = v.rd;
        p.rd_wen = v.fl[6]; p.is_branch = v.fl[5]; p.is_jump = v.fl[4];
        p.mem_rd = v.fl[3]; p.mem_wr = v.fl[2]; p.ebreak = v.fl[1]; p.illegal = v.fl[0];
        p.br_type = v.brt; p.target = v.tgt; p.mem_funct3 = v.mf3; p.store_data = v.rs2;
        return p;
    endfunction

    always_comb begin
        act = '0;
        act.pc = out_pc; act.alu_a = out_alu_a; act.alu_b = out_alu_b; act.alu_ctr = out_alu_ctr;
        act.rd = out_rd; act.rd_wen = out_rd_wen; act.is_branch = out_is_branch;
        act.is_jump = out_is_jump; act.br_type = out_br_type; act.target = out_target;
        act.mem_rd = out_mem_rd; act.mem_wr = out_mem_wr; act.mem_funct3 = out_mem_funct3;
        act.store_data = out_store_data; act.ebreak = out_ebreak; act.illegal = out_illegal;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Scoreboard: pop/compare on out transfer, push on in transfer, check holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && out_valid) begin
                n_cmp++;
                if (act !== held) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h expected %h", act, held);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pkt: got pc %h expected no packet", out_pc);
                end else begin
                    idu_pkt_t e;
                    e = sb.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL pkt pc=%h: got %h expected %h", e.pc, act, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            prev_hold <= out_valid && !out_ready && !flush;
            held      <= act;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Present one instruction at posedge+1 and hold it until accepted.
    task automatic send(input vec_t v);
        bit acc;
        bit first;
        acc = 1'b0;
        first = 1'b1;
        in_inst = v.inst; in_pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
        cur_exp = exp_of(v);
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (first) begin
                chk("rs1_addr", 32'(rs1_addr), 32'(v.inst[19:15]));
                chk("rs2_addr", 32'(rs2_addr), 32'(v.inst[24:20]));
                first = 1'b0;
            end
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || out_valid) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        vecs.push_back(mk(32'h00500093, 32'h100, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h5, 5'd1, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h402081B3, 32'h104, 32'd10, 32'd3, ALU_SUB, 32'd10, 32'd3, 5'd3, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h40335293, 32'h108, 32'hF0000000, 32'h0, ALU_SRA, 32'hF0000000, 32'd3, 5'd5, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h402091B3, 32'h10C, 32'd1, 32'd2, 4'h0, 32'h0, 32'h0, 5'd3, F_ILL, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h0020E463, 32'h80000000, 32'd5, 32'd7, ALU_SLTU, 32'd5, 32'd7, 5'd8, F_BR, 3'b110, 32'h80000008, 3'd0));
        vecs.push_back(mk(32'h010000EF, 32'h80000000, 32'h0, 32'h0, ALU_ADD, 32'h80000000, 32'd4, 5'd1, F_WEN | F_J, 3'd0, 32'h80000010, 3'd0));
        vecs.push_back(mk(32'h12345137, 32'h110, 32'h0, 32'h0, ALU_COPYB, 32'h0, 32'h12345000, 5'd2, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h00001197, 32'h200, 32'h0, 32'h0, ALU_ADD, 32'h200, 32'h1000, 5'd3, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h0080A203, 32'h204, 32'h1000, 32'h0, ALU_ADD, 32'h1000, 32'd8, 5'd4, F_WEN | F_MRD, 3'd0, 32'h0, 3'd2));
        vecs.push_back(mk(32'hFE20AE23, 32'h208, 32'h1000, 32'hDEAD, ALU_ADD, 32'h1000, 32'hFFFFFFFC, 5'd28, F_MWR, 3'd0, 32'h0, 3'd2));
        vecs.push_back(mk(32'h004280E7, 32'h300, 32'h1001, 32'h0, ALU_ADD, 32'h300, 32'd4, 5'd1, F_WEN | F_J, 3'd0, 32'h1004, 3'd0));
        vecs.push_back(mk(32'h00100073, 32'h304, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, F_EB, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h00100013, 32'h308, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'd1, 5'd0, F_NO, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h0020A463, 32'h30C, 32'd5, 32'd7, 4'h0, 32'h0, 32'h0, 5'd8, F_ILL, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h00000000, 32'h310, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, F_ILL, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h4020D3B3, 32'h314, 32'h80000000, 32'd4, ALU_SRA, 32'h80000000, 32'd4, 5'd7, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'hFFF0C093, 32'h318, 32'h55, 32'h0, ALU_XOR, 32'h55, 32'hFFFFFFFF, 5'd1, F_WEN, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h0020D463, 32'h1000, 32'd5, 32'd7, ALU_SLT, 32'd5, 32'd7, 5'd8, F_BR, 3'b101, 32'h1008, 3'd0));
        vecs.push_back(mk(32'h40109093, 32'h31C, 32'd1, 32'd1, 4'h0, 32'h0, 32'h0, 5'd1, F_ILL, 3'd0, 32'h0, 3'd0));
        vecs.push_back(mk(32'h00000073, 32'h320, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, F_ILL, 3'd0, 32'h0, 3'd0));

        // Reset values
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_ctr", 32'(out_alu_ctr), 32'd0);
        chk("rst_out_wen", 32'(out_rd_wen), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table pass
        out_ready = 1'b1;
        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Same table with random EXU back-pressure
        ready_rand = 1'b1;
        foreach (vecs[i]) send(vecs[i]);
        ready_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Stall for three cycles with a second instruction waiting
        out_ready = 1'b0;
        send(vecs[0]);
        in_inst = vecs[1].inst; in_pc = vecs[1].pc; rs1_data = vecs[1].rs1; rs2_data = vecs[1].rs2;
        cur_exp = exp_of(vecs[1]);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
`ifdef IDU_SKID_EN
            chk("stall_in_ready", 32'(in_ready), (k == 0) ? 32'd1 : 32'd0);
`else
            chk("stall_in_ready", 32'(in_ready), 32'd0);
`endif
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_pc", out_pc, vecs[0].pc);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_second_accepted", 32'(acc), 32'd1);
        drain();

        // Flush with a held packet and a waiting instruction
        out_ready = 1'b0;
        send(vecs[4]);
        in_inst = vecs[5].inst; in_pc = vecs[5].pc; rs1_data = vecs[5].rs1; rs2_data = vecs[5].rs2;
        cur_exp = exp_of(vecs[5]);
        in_valid = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a stall
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(vecs[2]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_b", out_alu_b, 32'h0);
        chk("arst_out_ctr", 32'(out_alu_ctr), 32'd0);
        chk("arst_out_rd", 32'(out_rd), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(vecs[6]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idu_alu_issue.md
Name: idu_alu_issue

Overview:
- Instruction-decode/issue stage for the RV32I NPC core. It is the producing end of the ALU control interface.
- Accepts fetched instructions and register-file read data from the IFU over a valid/ready handshake, and decodes them into an ALUctr code, ALUA/ALUB operands, writeback and branch/memory controls.
- Presents these on a registered output stage to the EXU over a second valid/ready handshake.
- Supports pipeline flush on redirect.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 0, reset value of out_pc (debug aid only).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- rs1_addr, rs2_addr  out  5  combinational inst[19:15], inst[24:20] to the regfile.
- rs1_data, rs2_data  in  XLEN  regfile read data, same cycle.
- flush  in  1  drop all held and incoming instructions.
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  EXU accepts the packet.
- out_pc  out  XLEN  PC of the packet.
- out_alu_a, out_alu_b  out  XLEN  ALU operands.
- out_alu_ctr  out  4  ALU op code.
- out_rd  out  5  destination register.
- out_rd_wen  out  1  writeback enable.
- out_is_branch  out  1  conditional branch.
- out_is_jump  out  1  JAL/JALR.
- out_br_type  out  3  funct3 of the branch.
- out_target  out  XLEN  branch/jump target.
- out_mem_rd, out_mem_wr  out  1  load/store.
- out_mem_funct3  out  3  access size/sign.
- out_store_data  out  XLEN  rs2_data.
- out_ebreak  out  1  EBREAK.
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset: all out_* registers are 0. out_pc resets to RESET_PC_TAG. out_valid=0. in_ready=1 after reset deasserts.
- ALUctr codes:
  - ADD 0000, SUB 1000, SLL 0001, SRL 0101, SRA 1101.
  - SLT 0010, SLTU 1010, COPYB 0011.
  - XOR 0100, OR 0110, AND 0111.
- Decode:
  - LUI: COPYB, A=0, B=imm_u.
  - AUIPC: ADD, A=pc, B=imm_u.
  - JAL: ADD, A=pc, B=4, jump, target=pc+imm_j.
  - JALR (funct3 000): ADD, A=pc, B=4, jump, target=(rs1+imm_i)&~1.
  - BRANCH:
    - A=rs1, B=rs2, wen=0, target=pc+imm_b.
    - BEQ/BNE: SUB.
    - BLT/BGE: SLT.
    - BLTU/BGEU: SLTU.
    - funct3 010/011 is illegal.
  - LOAD/STORE: ADD, A=rs1, B=imm_i or imm_s.
    - Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010.
  - OP-IMM: A=rs1, B=imm_i, op from funct3.
    - SLLI/SRLI/SRAI use B=shamt.
    - funct7 must be 0000000, except SRAI which is 0100000.
  - OP: A=rs1, B=rs2.
    - funct7 0100000 is legal only for SUB and SRA.
  - EBREAK: exactly 0x00100073 sets ebreak.
  - All other words are illegal: illegal=1, wen=0, ctr=0000, no mem/branch/jump.
- out_rd_wen is forced to 0 when rd==0.
- Handshake, latency 1 cycle:
  - Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
  - in_ready = ~flush & (~out_valid | out_ready). This is a combinational path from out_ready.
  - On transfer in, the output registers load the decoded packet and out_valid=1.
  - On transfer out with no transfer in, out_valid goes to 0.
  - While out_valid & ~out_ready, every out_* is held stable.
- Flush: out_valid=0 next cycle. in_ready=0 during the flush cycle, so the incoming instruction is dropped.
  - Flush coincident with transfer out: the transfer completes on the EXU side; the stage still clears.
- Reset mid-operation: the packet is discarded immediately (asynchronous), and outputs return to reset values.

Optional Feature:
- Macro IDU_SKID_EN.
- Defined:
  - Adds a one-entry skid register. in_ready = ~skid_valid & ~flush, driven purely from a register with no out_ready path.
  - On in transfer while out_valid & ~out_ready, the packet goes to the skid.
  - On the next out transfer, the skid moves into the output registers.
  - Order is preserved. Flush clears both entries.
- Undefined: single register stage as above.

Decomposition:
- Package idu_pkg:
  - ALUctr localparams (ALU_ADD .. ALU_AND).
  - RV32I opcode localparams.
  - Immediate-type enum.
- Sub-module idu_decode_comb: purely combinational inst/pc/rs data to packet. It also generates immediates and computes targets.
- idu_alu_issue holds the handshake/skid/flush sequencing.

Test Plan:
- addi x1,x0,5 (0x00500093), rs1_data=0 -> next cycle out_valid=1, a=0, b=5, ctr=0000, rd=1, wen=1.
- sub x3,x1,x2 (0x402081B3) -> ctr=1000. srai x5,x6,3 (0x40335293) -> ctr=1101, b=3. sll with funct7 0100000 -> illegal=1, wen=0.
- bltu x1,x2,+8 (0x0020E463), pc=0x80000000 -> ctr=1010, a=rs1, b=rs2, is_branch=1, br_type=110, target=0x80000008, wen=0.
- jal x1,+16 at pc=0x80000000 -> a=0x80000000, b=4, ctr=0000, is_jump=1, target=0x80000010, rd=1.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0 (with IDU_SKID_EN: exactly one extra accept, then in_ready=0). Both instructions exit in order.
- flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, in instruction not accepted. rst_n low mid-stall -> out_valid=0 immediately.
